// File: rtl/rr_latch_demux.sv
// rr_latch_demux: round-robin 1-to-2 latch demux; define RR_LATCH_DEMUX_XFER_COUNT_EN to add the xfer_count port
module rr_latch_demux #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] in,
  output logic             ready,
  input  logic             read0,
  input  logic             read1,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             valid0,
`ifdef RR_LATCH_DEMUX_XFER_COUNT_EN
  output logic             valid1,
  output logic [15:0]      xfer_count
`else
  output logic             valid1
`endif
);
  logic ptr;
  logic acc0;
  logic acc1;
  // the target slot can take a word if it is empty or being read this cycle
  always_comb begin
    ready = ptr ? (!valid1 || read1) : (!valid0 || read0);
    acc0  = write_en && ready && !ptr;
    acc1  = write_en && ready && ptr;
  end
  // an accept into a slot wins over a same-cycle read of that slot
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      out0   <= '0;
      out1   <= '0;
    end else begin
      ptr    <= ptr ^ (acc0 || acc1);
      valid0 <= acc0 || (valid0 && !read0);
      valid1 <= acc1 || (valid1 && !read1);
      if (acc0) out0 <= in;
      if (acc1) out1 <= in;
    end
  end
`ifdef RR_LATCH_DEMUX_XFER_COUNT_EN
  // free-running count of accepted words, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) xfer_count <= '0;
    else if (acc0 || acc1) xfer_count <= xfer_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rr_latch_demux.sv
// tb_rr_latch_demux: randomized and directed checks of rr_latch_demux against a slot/queue model
module tb_rr_latch_demux;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_en = 1'b0;
  logic [31:0] in = '0;
  logic        ready;
  logic        read0 = 1'b0;
  logic        read1 = 1'b0;
  logic [31:0] out0;
  logic [31:0] out1;
  logic        valid0;
  logic        valid1;
`ifdef RR_LATCH_DEMUX_XFER_COUNT_EN
  logic [15:0] xfer_count;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] md [2];
  bit          mf [2];
  int          mn;

  always #5 clk = ~clk;

  rr_latch_demux #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .in(in), .ready(ready),
    .read0(read0), .read1(read1), .out0(out0), .out1(out1),
`ifdef RR_LATCH_DEMUX_XFER_COUNT_EN
    .valid0(valid0), .valid1(valid1), .xfer_count(xfer_count)
`else
    .valid0(valid0), .valid1(valid1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: the n-th accepted word (counting from reset) goes to slot n%2.
  task automatic cyc(input bit rst, input bit we, input logic [31:0] d, input bit r0, input bit r1);
    int  k;
    bit  rd [2];
    bit  acc;
    @(negedge clk);
    reset = rst; write_en = we; in = d; read0 = r0; read1 = r1;
    k = mn % 2;
    rd[0] = r0;
    rd[1] = r1;
    acc = we && (!mf[k] || rd[k]);
    #1;
    if (!rst) check("ready", {31'd0, ready}, {31'd0, !mf[k] || rd[k]});
    @(posedge clk);
    if (rst) begin
      mf[0] = 0; mf[1] = 0; md[0] = '0; md[1] = '0; mn = 0;
    end else begin
      for (int s = 0; s < 2; s++) if (rd[s]) mf[s] = 0;
      if (acc) begin
        md[k] = d;
        mf[k] = 1;
        mn++;
      end
    end
    #1;
    check("valid0", {31'd0, valid0}, {31'd0, mf[0]});
    check("valid1", {31'd0, valid1}, {31'd0, mf[1]});
    check("out0", out0, md[0]);
    check("out1", out1, md[1]);
`ifdef RR_LATCH_DEMUX_XFER_COUNT_EN
    check("xfer_count", {16'd0, xfer_count}, mn % 65536);
`endif
  endtask

  task automatic idle_ready(input string tag, input bit exp);
    @(negedge clk);
    write_en = 0; read0 = 0; read1 = 0;
    #1;
    check(tag, {31'd0, ready}, {31'd0, exp});
  endtask

  initial begin
    mn = 0; mf[0] = 0; mf[1] = 0; md[0] = '0; md[1] = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle_ready("ready_after_reset", 1);
    cyc(0, 1, 32'hA5A5A5A5, 0, 0);
    cyc(0, 1, 32'h12345678, 0, 0);
    check("r030_out0", out0, 32'hA5A5A5A5);
    check("r030_out1", out1, 32'h12345678);
    idle_ready("r030_ready", 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'hDEADBEEF, 0, 0);
    check("r031_out0_hold", out0, 32'hA5A5A5A5);
    cyc(0, 1, 32'hDEADBEEF, 1, 0);
    check("r031_out0", out0, 32'hDEADBEEF);
    check("r031_valid0", {31'd0, valid0}, 32'd1);
    cyc(0, 1, 32'h0BADF00D, 0, 1);
    cyc(0, 1, 32'h00000001, 1, 0);
    check("r032_out0", out0, 32'h00000001);
    check("r032_valid0", {31'd0, valid0}, 32'd1);
    cyc(0, 1, 32'h00000077, 0, 1);
    check("r032_ptr_slot1", out1, 32'h00000077);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h00000055, 0, 0);
    check("r033_out0", out0, 32'h00000055);
    check("r033_valid1", {31'd0, valid1}, 32'd0);
    cyc(0, 1, 32'h00000066, 0, 0);
    cyc(1, 1, 32'hFFFFFFFF, 1, 0);
    check("r034_out0", out0, 32'h0);
    check("r034_out1", out1, 32'h0);
    check("r034_valid", {30'd0, valid1, valid0}, 32'd0);
    idle_ready("r034_ready", 1);
    cyc(0, 1, 32'hCAFE0000, 0, 0);
    check("r034_ptr0", out0, 32'hCAFE0000);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom,
          $urandom_range(2) == 0, $urandom_range(2) == 0);
`ifdef RR_LATCH_DEMUX_XFER_COUNT_EN
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 65537; i++) begin
      cyc(0, 1, $urandom, 1, 1);
      if (i == 65536) check("r035_wrap", {16'd0, xfer_count}, 32'h0000);
    end
    check("r035_count", {16'd0, xfer_count}, 32'h0001);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
